// File: rtl/grf_mp.sv
// Multi-port register file: combinational reads with optional write bypass, two prioritised write ports, pending-write scoreboard, registered write trace.
// Latency: reads 0 cycles, writes visible next cycle (same cycle with BYPASS=1), trace 1 cycle; no backpressure, every request is taken.
module grf_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wa_en,
    input  logic [ADDR_W-1:0]          wa_addr,
    input  logic [DATA_W-1:0]          wa_data,
    input  logic [31:0]                wa_pc,
    input  logic                       wb_en,
    input  logic [ADDR_W-1:0]          wb_addr,
    input  logic [DATA_W-1:0]          wb_data,
    input  logic [31:0]                wb_pc,
    input  logic                       bs_en,
    input  logic [ADDR_W-1:0]          bs_addr,
    output logic [1:0]                 tr_valid,
    output logic [ADDR_W-1:0]          tr_addr_a,
    output logic [DATA_W-1:0]          tr_data_a,
    output logic [31:0]                tr_pc_a,
    output logic [ADDR_W-1:0]          tr_addr_b,
    output logic [DATA_W-1:0]          tr_data_b,
    output logic [31:0]                tr_pc_b
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;

    // Clears first, then the set, so a new producer outlives a retiring one.
    always_comb begin
        busy_nxt = busy;
        if (wa_en) busy_nxt[wa_addr] = 1'b0;
        if (wb_en) busy_nxt[wb_addr] = 1'b0;
        if (bs_en) busy_nxt[bs_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            busy <= '0;
        end else begin
            // Port B is assigned last so it wins an address collision.
            if (wa_en && wa_addr != '0) mem[wa_addr] <= wa_data;
            if (wb_en && wb_addr != '0) mem[wb_addr] <= wb_data;
            busy <= busy_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tr_valid  <= '0;
            tr_addr_a <= '0;
            tr_data_a <= '0;
            tr_pc_a   <= '0;
            tr_addr_b <= '0;
            tr_data_b <= '0;
            tr_pc_b   <= '0;
        end else begin
            tr_valid <= {wb_en, wa_en};
            if (wa_en) begin
                tr_addr_a <= wa_addr;
                tr_data_a <= wa_data;
                tr_pc_a   <= wa_pc;
            end
            if (wb_en) begin
                tr_addr_b <= wb_addr;
                tr_data_b <= wb_data;
                tr_pc_b   <= wb_pc;
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;

        assign a = rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            d = mem[a];
            if (BYPASS != 0) begin
                if (wb_en && wb_addr == a)      d = wb_data;
                else if (wa_en && wa_addr == a) d = wa_data;
            end
            if (a == '0) d = '0;
        end

        assign rd_data[k*DATA_W +: DATA_W] = d;
        assign rd_busy[k] = (a != '0) && busy[a];
    end

endmodule
